alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter WIDTH, default 16, data width of register file, operands and writeback.
REQ-002 Parameter NREG, default 8, number of architectural registers; register index width is 3.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  instruction word present.
REQ-006 in_ready  output  1  stage accepts in_instr this cycle.
REQ-007 in_instr  input  16  fields: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [6:0] imm7 (LOAD/STR only).
REQ-008 out_valid  output  1  issue packet valid toward ALU.
REQ-009 out_ready  input  1  ALU/downstream consumes packet.
REQ-010 out_opcode  output  3  ALU opcode.
REQ-011 out_a, out_b  output  WIDTH each  ALU operands.
REQ-012 out_rd  output  3  destination register; out_wr output 1, destination is written.
REQ-013 out_sdata  output  WIDTH  store data for STR.
REQ-014 wb_en  input  1, wb_addr  input  3, wb_data  input  WIDTH  register writeback from downstream.
REQ-015 err_illegal  output  1  one-cycle pulse on an accepted illegal opcode.

Function
REQ-016 Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 DIV (a=R[rs1], b=R[rs2], wr=1); 100 LOAD (a=R[rs1], b=zero-extended imm7, wr=1); 101 STR (a=R[rs1], b=zero-extended imm7, sdata=R[rd], wr=0); 110/111 illegal.
REQ-017 R0 reads as 0, ignores writes, and is never pending.
REQ-018 Scoreboard: one pending bit per register; set on acceptance of a writing op for rd; cleared on wb_en for wb_addr; simultaneous set and clear of the same register -> set wins.
REQ-019 Hazard when any used source (rs1; rs2 for 000-011; rd for STR) is pending, or rd of a writing op is pending (WAW).
REQ-020 in_ready = (!out_valid || out_ready) && !hazard; illegal opcodes ignore hazard.
REQ-021 Accept = in_valid && in_ready; a legal accept loads the output packet and asserts out_valid after the same edge (latency 1 cycle).
REQ-022 out_valid && !out_ready holds all out_* fields stable; out_valid deasserts after a handshake with no new accept.
REQ-023 Accepted illegal opcode: no packet, no scoreboard change, err_illegal=1 for the next cycle only.
REQ-024 Register file writes wb_data on wb_en at the edge; reads are combinational.

Reset
REQ-025 rst: out_valid=0, err_illegal=0, all pending bits=0, all registers=0, out_* data fields=0; effective immediately, including mid-stall.

Configuration
REQ-026 Macro ALU_ISSUE_BYPASS_EN defined: a wb_en in the same cycle as a read of wb_addr clears that register's hazard and forwards wb_data to the operand.
REQ-027 Macro ALU_ISSUE_BYPASS_EN undefined: the pending bit stays visible that cycle (one-cycle stall); the value is read from the register file next cycle.

Structure
REQ-028 Package alu_pkg holds opcode constants (OP_ADD..OP_STR), instruction field positions and WIDTH default.
REQ-029 Sub-module alu_issue_regfile: NREG x WIDTH, two read ports plus store-data read port, one write port, R0 hardwired.

Verification
REQ-030 wb R1=28, R2=22; issue ADD rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, opcode=000, a=28, b=22, rd=3, wr=1; pending[3]=1.
REQ-031 RAW: after REQ-030, SUB rd=4 rs1=3 rs2=2 -> in_ready=0 until wb R3=50; then out a=50, b=22.
REQ-032 Backpressure: out_ready=0 for 3 cycles with packet held -> fields constant, in_ready=0; out_ready=1 -> next packet issues.
REQ-033 LOAD rd=5 rs1=1 imm7=32 with R1=10 -> a=10, b=32, wr=1; STR rd=5 rs1=2 imm7=40 with R5 pending -> stalled.
REQ-034 in_instr opcode 111 -> err_illegal one cycle, out_valid stays 0, pending unchanged.
REQ-035 Dependent ADD rs1=3 presented while wb R3=50 -> with ALU_ISSUE_BYPASS_EN issues same cycle with a=50; without it, one stall cycle then a=50.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared constants for the ALU issue stage: opcode encoding,
// instruction field positions, default sizes and opcode classification helpers.
package alu_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREG  = 8;
    localparam int IDX_W     = 3;
    localparam int INSTR_W   = 16;

    // Instruction field positions inside the 16-bit instruction word
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 4;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

    // Legal opcodes; 3'b110 and 3'b111 are illegal
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_LOAD = 3'b100,
        OP_STR  = 3'b101
    } opcode_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_STR;
    endfunction

    // Register-register ops read rs2; LOAD/STR use the immediate instead
    function automatic logic op_uses_rs2(input logic [2:0] op);
        return op <= OP_DIV;
    endfunction

    // Every legal op except STR writes rd
    function automatic logic op_writes(input logic [2:0] op);
        return op <= OP_LOAD;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile -- NREG x WIDTH architectural register file with two
// operand read ports, one store-data read port and one write port.
// R0 is hardwired to zero. Reads are combinational.
module alu_issue_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [IDX_W-1:0] i_rd_addr_a,
    input  logic [IDX_W-1:0] i_rd_addr_b,
    input  logic [IDX_W-1:0] i_rd_addr_s,
    output logic [WIDTH-1:0] o_rd_data_a,
    output logic [WIDTH-1:0] o_rd_data_b,
    output logic [WIDTH-1:0] o_rd_data_s
);

    logic [WIDTH-1:0] r_regs [NREG];

    // Writeback port; writes to R0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset because every register must read 0 after reset, which rules out mapping it onto a RAM macro.
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
    assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];
    assign o_rd_data_s = (i_rd_addr_s == '0) ? '0 : r_regs[i_rd_addr_s];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage -- decodes one instruction per cycle, checks the register
// scoreboard for RAW/WAW hazards, reads operands and hands a registered issue
// packet to the ALU over a valid/ready handshake.
// Optional build macro ALU_ISSUE_BYPASS_EN: a writeback in the same cycle as a
// read of that register clears its hazard and forwards wb_data to the operand.
// Without it the pending bit stays visible for that cycle (one stall).
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_opcode,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [IDX_W-1:0]   out_rd,
    output logic               out_wr,
    output logic [WIDTH-1:0]   out_sdata,
    input  logic               wb_en,
    input  logic [IDX_W-1:0]   wb_addr,
    input  logic [WIDTH-1:0]   wb_data,
    output logic               err_illegal
);

    // Instruction field decode
    logic [2:0]       w_opcode;
    logic [IDX_W-1:0] w_rd, w_rs1, w_rs2;
    logic [WIDTH-1:0] w_imm;

    assign w_opcode = in_instr[OPC_MSB:OPC_LSB];
    assign w_rd     = in_instr[RD_MSB:RD_LSB];
    assign w_rs1    = in_instr[RS1_MSB:RS1_LSB];
    assign w_rs2    = in_instr[RS2_MSB:RS2_LSB];
    assign w_imm    = WIDTH'(in_instr[IMM_MSB:IMM_LSB]);

    // Register file; the store-data port reads rd
    logic [WIDTH-1:0] w_rf_a, w_rf_b, w_rf_s;

    alu_issue_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (wb_en),
        .i_wr_addr   (wb_addr),
        .i_wr_data   (wb_data),
        .i_rd_addr_a (w_rs1),
        .i_rd_addr_b (w_rs2),
        .i_rd_addr_s (w_rd),
        .o_rd_data_a (w_rf_a),
        .o_rd_data_b (w_rf_b),
        .o_rd_data_s (w_rf_s)
    );

    // Scoreboard state and this cycle's set/clear masks
    logic [NREG-1:0] r_pending, w_pend_vis, w_wb_mask, w_set_mask;
    logic            r_out_valid, r_err_illegal, r_out_wr;
    logic [2:0]      r_opcode;
    logic [IDX_W-1:0] r_rd;
    logic [WIDTH-1:0] r_a, r_b, r_sdata;
    logic [WIDTH-1:0] w_src_a, w_src_b, w_src_s;
    logic             w_legal, w_hazard, w_accept, w_accept_legal;

    // One-hot of the register being written back (R0 excluded: never pending)
    always_comb begin
        // NOTE: default first so every path assigns the mask and no latch is inferred.
        w_wb_mask = '0;
        if (wb_en && (wb_addr != '0)) begin
            w_wb_mask[wb_addr] = 1'b1;
        end
    end

`ifdef ALU_ISSUE_BYPASS_EN
    // Same-cycle writeback hides the pending bit and supplies the operand value
    assign w_pend_vis = r_pending & ~w_wb_mask;
    assign w_src_a    = w_wb_mask[w_rs1] ? wb_data : w_rf_a;
    assign w_src_b    = w_wb_mask[w_rs2] ? wb_data : w_rf_b;
    assign w_src_s    = w_wb_mask[w_rd]  ? wb_data : w_rf_s;
`else
    // Pending bit stays visible this cycle; the value is read next cycle
    assign w_pend_vis = r_pending;
    assign w_src_a    = w_rf_a;
    assign w_src_b    = w_rf_b;
    assign w_src_s    = w_rf_s;
`endif

    // rs1 is always a source; rs2 only for reg-reg ops; rd is a source for STR
    // and a WAW target for writing ops, so every legal op checks it.
    assign w_legal  = op_legal(w_opcode);
    assign w_hazard = w_pend_vis[w_rs1]
                    | (op_uses_rs2(w_opcode) & w_pend_vis[w_rs2])
                    | (((w_opcode == OP_STR) | op_writes(w_opcode)) & w_pend_vis[w_rd]);

    // Illegal opcodes are swallowed regardless of hazards
    assign in_ready       = (!r_out_valid || out_ready) && (!w_legal || !w_hazard);
    assign w_accept       = in_valid && in_ready;
    assign w_accept_legal = w_accept && w_legal;

    // Destination of an accepted writing op becomes pending
    always_comb begin
        w_set_mask = '0;
        if (w_accept_legal && op_writes(w_opcode) && (w_rd != '0)) begin
            w_set_mask[w_rd] = 1'b1;
        end
    end

    // Scoreboard update: writeback clears, acceptance sets, set wins on collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_wb_mask) | w_set_mask;
        end
    end

    // Issue packet register: load on legal accept, hold while stalled, drop after handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_err_illegal <= 1'b0;
            r_opcode      <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_rd          <= '0;
            r_out_wr      <= 1'b0;
            r_sdata       <= '0;
        end else begin
            r_err_illegal <= w_accept && !w_legal;
            if (w_accept_legal) begin
                r_out_valid <= 1'b1;
                r_opcode    <= w_opcode;
                r_a         <= w_src_a;
                r_b         <= op_uses_rs2(w_opcode) ? w_src_b : w_imm;
                r_rd        <= w_rd;
                r_out_wr    <= op_writes(w_opcode);
                r_sdata     <= (w_opcode == OP_STR) ? w_src_s : '0;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_opcode  = r_opcode;
    assign out_a       = r_a;
    assign out_b       = r_b;
    assign out_rd      = r_rd;
    assign out_wr      = r_out_wr;
    assign out_sdata   = r_sdata;
    assign err_illegal = r_err_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage -- directed self-checking bench for alu_issue_stage.
// Expected stall counts follow ALU_ISSUE_BYPASS_EN when it is defined.
module tb_alu_issue_stage
    import alu_pkg::*;
;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_opcode;
    logic [15:0] out_a, out_b, out_sdata;
    logic [2:0]  out_rd;
    logic        out_wr;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        err_illegal;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls;
    bit ok;

    alu_issue_stage #(.WIDTH(16), .NREG(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_rd      (out_rd),
        .out_wr      (out_wr),
        .out_sdata   (out_sdata),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [15:0] mk_imm(input logic [2:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs1, input logic [6:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    // Hold in_valid until the stage accepts or the budget runs out; a
    // writeback pulse set up by the caller lasts exactly one cycle.
    task automatic wait_accept(input int max_cycles, output int n_stall, output bit acc);
        acc = 1'b0; n_stall = 0;
        for (int i = 0; i < max_cycles && !acc; i++) begin
            #1;
            if (in_ready) begin acc = 1'b1; n_stall = i; end
            step();
            wb_en = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b exp 0", out_valid); end
        n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b exp 0", err_illegal); end
        n_checks++; if (out_a !== 16'd0 || out_b !== 16'd0 || out_sdata !== 16'd0) begin n_fail++; $display("FAIL rst_data: got a=%0d b=%0d s=%0d exp 0", out_a, out_b, out_sdata); end
        n_checks++; if (out_rd !== 3'd0 || out_wr !== 1'b0 || out_opcode !== 3'd0) begin n_fail++; $display("FAIL rst_ctrl: got rd=%0d wr=%0b op=%0d exp 0", out_rd, out_wr, out_opcode); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b exp 1", in_ready); end
    endtask

    task automatic test_add();
        write_reg(3'd1, 16'd28);
        write_reg(3'd2, 16'd22);
        in_instr = mk(OP_ADD, 3'd3, 3'd1, 3'd2); in_valid = 1'b1;
        wait_accept(2, stalls, ok);
        n_checks++; if (!ok || stalls != 0) begin n_fail++; $display("FAIL add_accept: got ok=%0b stalls=%0d exp ok=1 stalls=0", ok, stalls); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %0b exp 1", out_valid); end
        n_checks++; if (out_opcode !== 3'b000) begin n_fail++; $display("FAIL add_opcode: got %0d exp 0", out_opcode); end
        n_checks++; if (out_a !== 16'd28) begin n_fail++; $display("FAIL add_a: got %0d exp 28", out_a); end
        n_checks++; if (out_b !== 16'd22) begin n_fail++; $display("FAIL add_b: got %0d exp 22", out_b); end
        n_checks++; if (out_rd !== 3'd3 || out_wr !== 1'b1) begin n_fail++; $display("FAIL add_rd_wr: got rd=%0d wr=%0b exp rd=3 wr=1", out_rd, out_wr); end
        in_instr = mk(OP_SUB, 3'd4, 3'd3, 3'd2);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_pending3: in_ready got %0b exp 0", in_ready); end
    endtask

    task automatic test_raw();
        in_instr = mk(OP_SUB, 3'd4, 3'd3, 3'd2); in_valid = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_drain: out_valid got %0b exp 0", out_valid); end
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall0: in_ready got %0b exp 0", in_ready); end
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall1: in_ready got %0b exp 0", in_ready); end
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'd50;
        wait_accept(4, stalls, ok);
        n_checks++; if (!ok || stalls != EXP_STALL) begin n_fail++; $display("FAIL raw_accept: got ok=%0b stalls=%0d exp ok=1 stalls=%0d", ok, stalls, EXP_STALL); end
        n_checks++; if (out_opcode !== 3'b001 || out_rd !== 3'd4) begin n_fail++; $display("FAIL raw_ctrl: got op=%0d rd=%0d exp op=1 rd=4", out_opcode, out_rd); end
        n_checks++; if (out_a !== 16'd50 || out_b !== 16'd22) begin n_fail++; $display("FAIL raw_ops: got a=%0d b=%0d exp a=50 b=22", out_a, out_b); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_instr = mk_imm(OP_LOAD, 3'd5, 3'd1, 7'd32); in_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'd10;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_hs[%0d]: got v=%0b rdy=%0b exp v=1 rdy=0", i, out_valid, in_ready); end
            n_checks++; if (out_a !== 16'd50 || out_b !== 16'd22) begin n_fail++; $display("FAIL bp_hold_ops[%0d]: got a=%0d b=%0d exp a=50 b=22", i, out_a, out_b); end
            n_checks++; if (out_opcode !== 3'b001 || out_rd !== 3'd4 || out_wr !== 1'b1) begin n_fail++; $display("FAIL bp_hold_ctrl[%0d]: got op=%0d rd=%0d wr=%0b exp 1/4/1", i, out_opcode, out_rd, out_wr); end
            step();
            wb_en = 1'b0;
        end
        out_ready = 1'b1;
        wait_accept(2, stalls, ok);
        n_checks++; if (!ok || stalls != 0) begin n_fail++; $display("FAIL bp_release: got ok=%0b stalls=%0d exp ok=1 stalls=0", ok, stalls); end
        n_checks++; if (out_opcode !== 3'b100 || out_rd !== 3'd5 || out_wr !== 1'b1) begin n_fail++; $display("FAIL load_ctrl: got op=%0d rd=%0d wr=%0b exp 4/5/1", out_opcode, out_rd, out_wr); end
        n_checks++; if (out_a !== 16'd10 || out_b !== 16'd32) begin n_fail++; $display("FAIL load_ops: got a=%0d b=%0d exp a=10 b=32", out_a, out_b); end
    endtask

    task automatic test_store();
        in_instr = mk_imm(OP_STR, 3'd5, 3'd2, 7'd40); in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL str_stall0: in_ready got %0b exp 0", in_ready); end
        step();
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL str_stall1: got rdy=%0b v=%0b exp 0/0", in_ready, out_valid); end
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'd77;
        wait_accept(4, stalls, ok);
        n_checks++; if (!ok || stalls != EXP_STALL) begin n_fail++; $display("FAIL str_accept: got ok=%0b stalls=%0d exp ok=1 stalls=%0d", ok, stalls, EXP_STALL); end
        n_checks++; if (out_opcode !== 3'b101 || out_rd !== 3'd5 || out_wr !== 1'b0) begin n_fail++; $display("FAIL str_ctrl: got op=%0d rd=%0d wr=%0b exp 5/5/0", out_opcode, out_rd, out_wr); end
        n_checks++; if (out_a !== 16'd22 || out_b !== 16'd40 || out_sdata !== 16'd77) begin n_fail++; $display("FAIL str_ops: got a=%0d b=%0d s=%0d exp 22/40/77", out_a, out_b, out_sdata); end
    endtask

    task automatic test_illegal();
        in_instr = {3'b111, 3'd6, 3'd4, 3'd4, 4'b0000}; in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready: got %0b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (err_illegal !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_pulse: got err=%0b v=%0b exp 1/0", err_illegal, out_valid); end
        step();
        n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_one_cycle: got %0b exp 0", err_illegal); end
        in_instr = mk(OP_ADD, 3'd7, 3'd6, 3'd0);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_no_set: in_ready got %0b exp 1", in_ready); end
        in_instr = mk(OP_ADD, 3'd7, 3'd4, 3'd0);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ill_keep_r4: in_ready got %0b exp 0", in_ready); end
    endtask

    task automatic test_bypass();
        in_instr = mk(OP_ADD, 3'd3, 3'd1, 3'd2); in_valid = 1'b1;
        wait_accept(2, stalls, ok);
        n_checks++; if (!ok || out_a !== 16'd10) begin n_fail++; $display("FAIL byp_setup: got ok=%0b a=%0d exp ok=1 a=10", ok, out_a); end
        in_instr = mk(OP_ADD, 3'd6, 3'd3, 3'd0); in_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'd91;
        wait_accept(4, stalls, ok);
        n_checks++; if (!ok || stalls != EXP_STALL) begin n_fail++; $display("FAIL byp_stalls: got ok=%0b stalls=%0d exp ok=1 stalls=%0d", ok, stalls, EXP_STALL); end
        n_checks++; if (out_a !== 16'd91 || out_b !== 16'd0 || out_rd !== 3'd6) begin n_fail++; $display("FAIL byp_ops: got a=%0d b=%0d rd=%0d exp 91/0/6", out_a, out_b, out_rd); end
    endtask

    task automatic test_set_wins();
        in_instr = mk(OP_ADD, 3'd7, 3'd1, 3'd2); in_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 3'd7; wb_data = 16'd33;
        wait_accept(2, stalls, ok);
        n_checks++; if (!ok || stalls != 0) begin n_fail++; $display("FAIL sw_accept: got ok=%0b stalls=%0d exp ok=1 stalls=0", ok, stalls); end
        in_instr = mk(OP_ADD, 3'd1, 3'd7, 3'd0);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sw_pending7: in_ready got %0b exp 0", in_ready); end
        in_instr = mk_imm(OP_LOAD, 3'd6, 3'd1, 7'd1);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_r6: in_ready got %0b exp 0", in_ready); end
    endtask

    task automatic test_r0();
        write_reg(3'd0, 16'd99);
        in_instr = mk(OP_ADD, 3'd0, 3'd0, 3'd0); in_valid = 1'b1;
        wait_accept(2, stalls, ok);
        n_checks++; if (!ok || out_a !== 16'd0 || out_b !== 16'd0) begin n_fail++; $display("FAIL r0_read: got ok=%0b a=%0d b=%0d exp 1/0/0", ok, out_a, out_b); end
        n_checks++; if (out_rd !== 3'd0 || out_wr !== 1'b1) begin n_fail++; $display("FAIL r0_ctrl: got rd=%0d wr=%0b exp 0/1", out_rd, out_wr); end
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL r0_not_pending: in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_reset_mid_stall();
        in_instr = mk(OP_ADD, 3'd2, 3'd1, 3'd1); in_valid = 1'b1;
        wait_accept(2, stalls, ok);
        out_ready = 1'b0;
        step();
        n_checks++; if (!ok || out_valid !== 1'b1 || out_a !== 16'd10) begin n_fail++; $display("FAIL ms_held: got ok=%0b v=%0b a=%0d exp 1/1/10", ok, out_valid, out_a); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || err_illegal !== 1'b0) begin n_fail++; $display("FAIL ms_rst_valid: got v=%0b err=%0b exp 0/0", out_valid, err_illegal); end
        n_checks++; if (out_a !== 16'd0 || out_b !== 16'd0 || out_rd !== 3'd0 || out_wr !== 1'b0) begin n_fail++; $display("FAIL ms_rst_data: got a=%0d b=%0d rd=%0d wr=%0b exp 0", out_a, out_b, out_rd, out_wr); end
        #2;
        rst = 1'b0;
        in_instr = mk(OP_ADD, 3'd1, 3'd7, 3'd2);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ms_pending_clr: in_ready got %0b exp 1", in_ready); end
        out_ready = 1'b1; in_valid = 1'b1;
        wait_accept(2, stalls, ok);
        n_checks++; if (!ok || out_a !== 16'd0 || out_b !== 16'd0) begin n_fail++; $display("FAIL ms_regs_clr: got ok=%0b a=%0d b=%0d exp 1/0/0", ok, out_a, out_b); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_raw();
        test_backpressure();
        test_store();
        test_illegal();
        test_bypass();
        test_set_wins();
        test_r0();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
